// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead byte FIFO and sticky error flags.
// The consumer sees the head byte combinationally and pops it with rd_en.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta_q, rxs_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push, frame_evt;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic          pop, full, wr_en, ovr_evt;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        cnt_d   = HALF_LOAD;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (!rxs_q) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                            cnt_d     = FULL_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shreg_d = {rxs_q, shreg_q[7:1]};
                        cnt_d   = FULL_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        push      = rxs_q;
                        frame_evt = !rxs_q;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pop on a full FIFO frees the slot the concurrent push writes into.
    assign pop     = rd_en && (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign wr_en   = push && (!full || pop);
    assign ovr_evt = push && full && !pop;

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        frame_err_d = (frame_err_q & ~clr_err) | frame_evt;
        overrun_d   = (overrun_q & ~clr_err) | ovr_evt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-frame/pop/clear
// steps plus hand sequences for glitch, ena abort, full-FIFO pop and reset.
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int OP_FRAME = 0;
    localparam int OP_POP   = 1;
    localparam int OP_CLR   = 2;
    localparam int NVEC     = 17;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         op;
        logic [7:0] data;
        logic       stop_ok;
        int         gap;
        logic       ev;
        logic [7:0] ed;
        int         ec;
        logic       efe;
        logic       eov;
    } vec_t;

    vec_t vecs [NVEC];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rx         (rx),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic v, input logic [7:0] d,
                              input int c, input logic fe, input logic ov);
        chk({name, ".rd_valid"},   32'(rd_valid),   32'(v));
        chk({name, ".rd_data"},    32'(rd_data),    32'(d));
        chk({name, ".fifo_count"}, 32'(fifo_count), 32'(c));
        chk({name, ".frame_err"},  32'(frame_err),  32'(fe));
        chk({name, ".overrun"},    32'(overrun),    32'(ov));
    endtask

    // Every step ends 1ns after a rising edge, so outputs are sampled off the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    // pop_at_stop raises rd_en for exactly the edge on which the stop bit is sampled.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic pop_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        rx = stop_ok;
        if (pop_at_stop) begin
            tick(CPB - 2);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(1);
        end else begin
            tick(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic pop_once();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_FRAME, 8'hA5, 1'b1, 2, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
        vecs[1]  = '{OP_POP,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        vecs[2]  = '{OP_FRAME, 8'h01, 1'b1, 0, 1'b1, 8'h01, 1, 1'b0, 1'b0};
        vecs[3]  = '{OP_FRAME, 8'h02, 1'b1, 0, 1'b1, 8'h01, 2, 1'b0, 1'b0};
        vecs[4]  = '{OP_FRAME, 8'h03, 1'b1, 0, 1'b1, 8'h01, 3, 1'b0, 1'b0};
        vecs[5]  = '{OP_FRAME, 8'h04, 1'b1, 0, 1'b1, 8'h01, 4, 1'b0, 1'b0};
        vecs[6]  = '{OP_FRAME, 8'h05, 1'b1, 2, 1'b1, 8'h01, 4, 1'b0, 1'b1};
        vecs[7]  = '{OP_POP,   8'h00, 1'b1, 0, 1'b1, 8'h02, 3, 1'b0, 1'b1};
        vecs[8]  = '{OP_POP,   8'h00, 1'b1, 0, 1'b1, 8'h03, 2, 1'b0, 1'b1};
        vecs[9]  = '{OP_POP,   8'h00, 1'b1, 0, 1'b1, 8'h04, 1, 1'b0, 1'b1};
        vecs[10] = '{OP_POP,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1};
        vecs[11] = '{OP_CLR,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        vecs[12] = '{OP_FRAME, 8'h3C, 1'b0, 4, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        vecs[13] = '{OP_FRAME, 8'h3C, 1'b1, 2, 1'b1, 8'h3C, 1, 1'b1, 1'b0};
        vecs[14] = '{OP_POP,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        vecs[15] = '{OP_CLR,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        vecs[16] = '{OP_POP,   8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0};

        // Reset values
        rst_n = 1'b0;
        tick(3);
        check_outs("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Table-driven frames, pops and flag clears
        for (int i = 0; i < NVEC; i++) begin
            case (vecs[i].op)
                OP_FRAME: send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0);
                OP_POP:   pop_once();
                default: begin
                    clr_err = 1'b1;
                    tick(1);
                    clr_err = 1'b0;
                end
            endcase
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                       vecs[i].efe, vecs[i].eov);
            tick(vecs[i].gap);
        end

        // Short low glitch on rx must be rejected at the start-bit sample
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check_outs("glitch", 1'b0, 8'h00, 0, 1'b0, 1'b0);

        // Dropping ena mid-frame discards the partial byte
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick(40);
                ena = 1'b0;
                tick(1);
                ena = 1'b1;
            end
        join
        tick(4);
        check_outs("ena_abort", 1'b0, 8'h00, 0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_outs("after_abort", 1'b1, 8'h5A, 1, 1'b0, 1'b0);
        pop_once();
        check_outs("after_abort_pop", 1'b0, 8'h00, 0, 1'b0, 1'b0);

        // Fill, then pop on the very edge the fifth byte is pushed
        exp_q.delete();
        send_frame(8'h11, 1'b1, 1'b0); exp_q.push_back(8'h11);
        send_frame(8'h22, 1'b1, 1'b0); exp_q.push_back(8'h22);
        send_frame(8'h33, 1'b1, 1'b0); exp_q.push_back(8'h33);
        send_frame(8'h44, 1'b1, 1'b0); exp_q.push_back(8'h44);
        check_outs("fill4", 1'b1, exp_q[0], 4, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        check_outs("full_pop_push", 1'b1, exp_q[0], exp_q.size(), 1'b0, 1'b0);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            pop_once();
            chk($sformatf("drain%0d.fifo_count", i), 32'(fifo_count), 32'(exp_q.size()));
        end
        check_outs("drained", 1'b0, 8'h00, 0, 1'b0, 1'b0);

        // Pop request on an empty FIFO while a byte is pushed: push wins
        send_frame(8'h99, 1'b1, 1'b1);
        check_outs("empty_pop_push", 1'b1, 8'h99, 1, 1'b0, 1'b0);
        pop_once();
        tick(2);

        // Reset in the middle of a frame with flags set and bytes buffered
        send_frame(8'hC3, 1'b0, 1'b0);
        tick(4);
        send_frame(8'hAB, 1'b1, 1'b0);
        send_frame(8'hCD, 1'b1, 1'b0);
        check_outs("pre_reset", 1'b1, 8'hAB, 2, 1'b1, 1'b0);
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick(30);
                rst_n = 1'b0;
                tick(1);
                check_outs("mid_reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
        join
        tick(4);
        send_frame(8'h6E, 1'b1, 1'b0);
        check_outs("post_reset", 1'b1, 8'h6E, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
